// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use and compare-branch operand stalls,
// data-memory wait freezes, taken-branch IF/ID flush and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_Rw,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_Rw,
    input  logic [4:0]       IF_ID_Ra,
    input  logic [4:0]       IF_ID_Rb,
    input  logic             IF_ID_UseRa,
    input  logic             IF_ID_UseRb,
    input  logic             IF_ID_IsCB,
    input  logic             BranchTaken,
    input  logic             DMem_Req,
    input  logic             DMem_Ready,
    input  logic             StallCountClr,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             PipeFreeze,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {StRun, StStall, StFreeze} state_e;

    localparam logic [4:0] ZeroReg = 5'd31;

    state_e           r_state, w_state_d;
    state_e           r_saved_state, w_saved_state_d;
    state_e           w_eff_state;
    logic             r_rem, w_rem_d;
    logic             r_saved_rem, w_saved_rem_d;
    logic             w_eff_rem;
    logic             w_lu, w_c1, w_c2, w_frz, w_hazard;
    logic [CNT_W-1:0] r_count;

    // Hazard terms; X31 is hard-wired zero and never a dependency.
    always_comb begin
        w_lu  = ID_EX_MemRead && (ID_EX_Rw != ZeroReg) &&
                ((IF_ID_UseRa && (IF_ID_Ra == ID_EX_Rw)) ||
                 (IF_ID_UseRb && (IF_ID_Rb == ID_EX_Rw)));
        w_c2  = IF_ID_IsCB && ID_EX_MemRead && (ID_EX_Rw == IF_ID_Rb) &&
                (IF_ID_Rb != ZeroReg);
        w_c1  = IF_ID_IsCB && (IF_ID_Rb != ZeroReg) &&
                ((ID_EX_RegWrite && !ID_EX_MemRead && (ID_EX_Rw == IF_ID_Rb)) ||
                 (EX_MEM_MemRead && (EX_MEM_Rw == IF_ID_Rb)));
        w_frz    = DMem_Req && !DMem_Ready;
        w_hazard = w_lu || w_c1 || w_c2;
    end

    // While frozen, the state we act as once the freeze drops is the saved one.
    always_comb begin
        w_eff_state = (r_state == StFreeze) ? r_saved_state : r_state;
        w_eff_rem   = (r_state == StFreeze) ? r_saved_rem   : r_rem;
    end

    // Next-state and same-cycle control outputs; priority reset > freeze > stall > flush.
    always_comb begin
        PCWrite         = 1'b1;
        IF_ID_Write     = 1'b1;
        IF_ID_Flush     = 1'b0;
        ID_EX_Bubble    = 1'b0;
        PipeFreeze      = 1'b0;
        w_state_d       = r_state;
        w_rem_d         = r_rem;
        w_saved_state_d = r_saved_state;
        w_saved_rem_d   = r_saved_rem;

        if (!reset) begin
            w_state_d       = StRun;
            w_rem_d         = 1'b0;
            w_saved_state_d = StRun;
            w_saved_rem_d   = 1'b0;
        end else if (w_frz) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            PipeFreeze  = 1'b1;
            w_state_d   = StFreeze;
            // Save only on entry so a long freeze keeps the original context.
            if (r_state != StFreeze) begin
                w_saved_state_d = r_state;
                w_saved_rem_d   = r_rem;
            end
        end else begin
            w_saved_state_d = StRun;
            w_saved_rem_d   = 1'b0;
            w_rem_d         = w_eff_rem;
            if (w_eff_state == StStall) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                // rem counts stall cycles left including this one.
                if (w_eff_rem) begin
                    w_rem_d = 1'b0;
                end
                w_state_d = StRun;
            end else if (w_hazard) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
                if (w_c2) begin
                    w_state_d = StStall;
                    w_rem_d   = 1'b1;
                end else begin
                    w_state_d = StRun;
                end
            end else begin
                IF_ID_Flush = BranchTaken;
                w_state_d   = StRun;
            end
        end
    end

    // FSM state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= StRun;
            r_rem         <= 1'b0;
            r_saved_state <= StRun;
            r_saved_rem   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_rem         <= w_rem_d;
            r_saved_state <= w_saved_state_d;
            r_saved_rem   <= w_saved_rem_d;
        end
    end

    // Saturating count of cycles with the PC held; clear beats increment.
    always_ff @(posedge clk) begin
        if (!reset || StallCountClr) begin
            r_count <= '0;
        end else if (!PCWrite && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign StallCount = r_count;

endmodule
